hs_mem_arb: RTL and testbench
=============================

# hs_mem_arb

Two-requester arbiter that shares one single-outstanding handshake memory (valid/ready command port plus valid/ready read-response port) between requester 0 and requester 1. It selects one command per transfer, forwards it to the memory, and locks the memory to the read owner until that read's response is delivered back. The block sits between the two command sources and the memory; all paths are combinational pass-through, and only arbitration state is registered.

## Interface
Parameters:
- DATA_WD, 4, data width of write data and read data
- ADDR_WD, 4, memory address width

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command valid
- req_cmd  in  2  per-requester command, 1 = write, 0 = read
- req_addr  in  2*ADDR_WD  per-requester address, requester i at [i*ADDR_WD +: ADDR_WD]
- req_wdata  in  2*DATA_WD  per-requester write data, same packing
- req_ready  out  2  per-requester command accept
- rsp_valid  out  2  per-requester read-response valid
- rsp_data  out  DATA_WD  read data, shared by both requesters, qualified by rsp_valid
- rsp_ready  in  2  per-requester response accept
- mem_valid, mem_cmd, mem_addr, mem_wdata  out  1/1/ADDR_WD/DATA_WD  command to memory
- mem_ready  in  1  memory command accept
- mem_rvalid, mem_rdata  in  1/DATA_WD  memory read response
- mem_rready  out  1  response accept to memory

## Operation
- Command fire: mem_valid && mem_ready. Response fire: mem_rvalid && mem_rready.
- States:
  - ARB: when no requester is valid, all mem and req outputs are 0. When one or more requesters are valid, the winner w is requester i if only i is valid. If both are valid, w = !last (round-robin). mem_* is driven from requester w, req_ready[w] = mem_ready, and the other req_ready is 0.
    - Write fire: stay in ARB and set last <= w.
    - Read fire: go to RD_WAIT, set owner <= w and last <= w.
    - Valid without fire: go to HOLD and set owner <= w.
  - HOLD: the grant is frozen to owner, and mem_* is driven from the owner only. The other requester sees req_ready = 0 even if it is valid. Write fire goes to ARB. Read fire goes to RD_WAIT. If the owner drops valid (a protocol violation), return to ARB with no transfer.
  - RD_WAIT: mem_valid = 0 and req_ready = 2'b00. rsp_valid[owner] = mem_rvalid, rsp_data = mem_rdata, mem_rready = rsp_ready[owner], and the other rsp_valid is 0. Response fire goes to ARB.
- In ARB and HOLD, mem_rready = 0 and rsp_valid = 0.
- last and owner are 1-bit registers.
- The memory is single-outstanding, so at most one read is in flight.

## Timing
- Command path is zero latency (combinational req → mem). req_ready is combinational from mem_ready.
- Response path is zero latency (combinational mem_r → rsp).
- Back-to-back writes from alternating requesters sustain one write per cycle.
- After a read, the next command can fire no earlier than the cycle after the response fire.
- Reset values:
  - state = ARB, last = 1 (requester 0 wins the first tie), owner = 0.
  - All outputs are 0 while no request is present.
- Reset asserted mid-read returns to ARB. The abandoned response is not forwarded; the memory is reset by the same rstn.
- A request that arrives in the same cycle as a response fire is arbitrated in the next cycle, not the same cycle.

## Configuration
- HS_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins a tie. last is still updated but ignored.
  - Undefined: round-robin as described above.
- The HOLD lock applies in both modes.

## Structure
- Shared package hs_pkg:
  - state encoding localparams ARB = 2'd0, HOLD = 2'd1, RD_WAIT = 2'd2
  - CMD_WR = 1'b1 and CMD_RD = 1'b0
- One natural sub-module, hs_rr_pick: a 2-way round-robin pick (inputs valid[1:0] and last; output winner). It also carries the fixed-priority mode under HS_ARB_FIXED_PRIO_EN.

## Test plan
- Single writer: req0 writes addr 3, data 0xA with mem_ready = 1 → mem_valid = 1 with addr 3 in the same cycle, req_ready = 2'b01, state stays ARB.
- Tie round-robin: both requesters issue writes continuously → the grants alternate 0, 1, 0, 1 over 4 cycles. With HS_ARB_FIXED_PRIO_EN, requester 0 wins all 4.
- Read lock: req1 reads addr 5 while req0 keeps a write pending. Hold mem_rvalid low 3 cycles, then return 0x7 → req_ready stays 0 throughout. rsp_valid = 2'b10 with rsp_data = 0x7. req0's write fires the cycle after the response fire.
- Backpressure hold: both requesters valid, mem_ready = 0 for 2 cycles → the grant stays on the first winner (state HOLD) and no switch occurs. The fire occurs when mem_ready = 1.
- Response backpressure: in RD_WAIT with rsp_ready[owner] = 0 and mem_rvalid = 1 → mem_rready = 0 and the state holds until rsp_ready = 1.
- Reset during RD_WAIT: assert rstn low → state goes to ARB, outputs are 0 and last = 1. After release, a tie is won by requester 0.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared state encoding and command codes for the handshake memory arbiter.
package hs_pkg;
  typedef enum logic [1:0] {ARB = 2'd0, HOLD = 2'd1, RD_WAIT = 2'd2} state_t;
  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;
endpackage

// File: rtl/hs_rr_pick.sv
// hs_rr_pick: 2-way round-robin pick; HS_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module hs_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       winner
);
`ifdef HS_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign winner = ~valid[0];
`else
  assign winner = &valid ? ~last : valid[1];
`endif
endmodule

// File: rtl/hs_mem_arb.sv
// hs_mem_arb: two-requester arbiter for a single-outstanding valid/ready memory.
// Tie policy selected by HS_ARB_FIXED_PRIO_EN (see hs_rr_pick).
module hs_mem_arb
  import hs_pkg::*;
#(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_cmd,
  input  logic [2*ADDR_WD-1:0] req_addr,
  input  logic [2*DATA_WD-1:0] req_wdata,
  output logic [1:0]           req_ready,
  output logic [1:0]           rsp_valid,
  output logic [DATA_WD-1:0]   rsp_data,
  input  logic [1:0]           rsp_ready,
  output logic                 mem_valid,
  output logic                 mem_cmd,
  output logic [ADDR_WD-1:0]   mem_addr,
  output logic [DATA_WD-1:0]   mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [DATA_WD-1:0]   mem_rdata,
  output logic                 mem_rready
);
  state_t state_q, state_d;
  logic last_q, last_d, owner_q, owner_d;
  logic winner, sel, active, rd, cmd_fire, rsp_fire;

  hs_rr_pick u_pick (.valid(req_valid), .last(last_q), .winner(winner));

  always_comb begin
    rd = state_q == RD_WAIT;
    sel = state_q == HOLD ? owner_q : winner;
    active = state_q == ARB ? |req_valid : state_q == HOLD && req_valid[owner_q];
    mem_valid = active;
    mem_cmd = active & req_cmd[sel];
    mem_addr = !active ? '0 : sel ? req_addr[2*ADDR_WD-1:ADDR_WD] : req_addr[ADDR_WD-1:0];
    mem_wdata = !active ? '0 : sel ? req_wdata[2*DATA_WD-1:DATA_WD] : req_wdata[DATA_WD-1:0];
    req_ready = active ? {sel, ~sel} & {2{mem_ready}} : 2'b00;
    rsp_valid = rd ? {owner_q, ~owner_q} & {2{mem_rvalid}} : 2'b00;
    rsp_data = rd ? mem_rdata : '0;
    mem_rready = rd & rsp_ready[owner_q];
    cmd_fire = mem_valid & mem_ready;
    rsp_fire = mem_rvalid & mem_rready;
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    if (rd) state_d = rsp_fire ? ARB : RD_WAIT;
    else if (!active) state_d = ARB;
    else if (cmd_fire) begin
      state_d = mem_cmd == CMD_WR ? ARB : RD_WAIT;
      last_d = sel;
      owner_d = mem_cmd == CMD_RD ? sel : owner_q;
    end else begin
      state_d = HOLD;
      owner_d = sel;
    end
  end

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
      last_q <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: tb/tb_hs_mem_arb.sv
// tb_hs_mem_arb: directed scoreboard bench for hs_mem_arb; honours HS_ARB_FIXED_PRIO_EN.
module tb_hs_mem_arb;
`ifdef HS_ARB_FIXED_PRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif
  logic clk = 1'b0, rstn;
  logic [1:0] req_valid, req_cmd, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_addr, req_wdata;
  logic [3:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic mem_valid, mem_cmd, mem_ready, mem_rvalid, mem_rready;
  int tests = 0, fails = 0;
  logic [10:0] cq[$];
  logic [5:0] rq[$];

  always #5 clk = ~clk;

  hs_mem_arb #(.DATA_WD(4), .ADDR_WD(4)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .mem_valid(mem_valid), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rready(mem_rready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int i, input logic v, input logic c, input logic [3:0] a, input logic [3:0] d);
    req_valid[i] = v;
    req_cmd[i] = c;
    req_addr[i*4 +: 4] = a;
    req_wdata[i*4 +: 4] = d;
  endtask

  task automatic push_cmd(input logic w, input logic c, input logic [3:0] a, input logic [3:0] d);
    cq.push_back({w ? 2'b10 : 2'b01, c, a, d});
  endtask

  task automatic observe;
    logic [10:0] ec;
    logic [5:0] er;
    #1;
    if (mem_valid && mem_ready) begin
      ec = cq.size() != 0 ? cq.pop_front() : 11'h7ff;
      chk("cmd_fire", {5'd0, req_ready, mem_cmd, mem_addr, mem_wdata}, {5'd0, ec});
    end
    if (|(rsp_valid & rsp_ready)) begin
      er = rq.size() != 0 ? rq.pop_front() : 6'h3f;
      chk("rsp_fire", {10'd0, rsp_valid, rsp_data}, {10'd0, er});
    end
  endtask

  initial begin
    logic w;
    rstn = 1'b0; req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick;
    chk("rst_mem_valid", 16'(mem_valid), 16'd0);
    chk("rst_req_ready", 16'(req_ready), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_mem_rready", 16'(mem_rready), 16'd0);
    tick;
    rstn = 1'b1;
    // continuous tie of writes
    setr(0, 1, 1, 4'd1, 4'h1); setr(1, 1, 1, 4'd2, 4'h2); mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = FIX ? 1'b0 : k[0];
      push_cmd(w, 1'b1, w ? 4'd2 : 4'd1, w ? 4'h2 : 4'h1);
      observe;
      chk("tie_grant", 16'(req_ready), w ? 16'd2 : 16'd1);
      tick;
    end
    // single writer
    req_valid = '0; setr(0, 1, 1, 4'd3, 4'hA); push_cmd(0, 1, 4'd3, 4'hA);
    observe;
    chk("sw_mem_valid", 16'(mem_valid), 16'd1);
    chk("sw_addr", 16'(mem_addr), 16'd3);
    chk("sw_req_ready", 16'(req_ready), 16'd1);
    tick;
    req_valid = '0; setr(1, 1, 1, 4'd4, 4'hB); push_cmd(1, 1, 4'd4, 4'hB);
    observe;
    chk("sw_next_ready", 16'(req_ready), 16'd2);
    tick;
    // read lock: req1 reads, req0 write waits
    req_valid = '0; setr(1, 1, 0, 4'd5, 4'h0); push_cmd(1, 0, 4'd5, 4'h0); rq.push_back({2'b10, 4'h7});
    observe;
    chk("rd_issue_ready", 16'(req_ready), 16'd2);
    tick;
    req_valid = '0; setr(0, 1, 1, 4'd6, 4'h9); rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      observe;
      chk("rd_lock_ready", 16'(req_ready), 16'd0);
      chk("rd_lock_mem_valid", 16'(mem_valid), 16'd0);
      chk("rd_wait_rsp_valid", 16'(rsp_valid), 16'd0);
      tick;
    end
    mem_rvalid = 1'b1; mem_rdata = 4'h7;
    observe;
    chk("rd_rsp_valid", 16'(rsp_valid), 16'd2);
    chk("rd_rsp_data", 16'(rsp_data), 16'd7);
    chk("rd_mem_rready", 16'(mem_rready), 16'd1);
    chk("rd_fire_req_ready", 16'(req_ready), 16'd0);
    tick;
    mem_rvalid = 1'b0; mem_rdata = '0; push_cmd(0, 1, 4'd6, 4'h9);
    observe;
    chk("rd_after_ready", 16'(req_ready), 16'd1);
    tick;
    // response backpressure on a req0 read
    req_valid = '0; rsp_ready = '0; setr(0, 1, 0, 4'd4, 4'h0); push_cmd(0, 0, 4'd4, 4'h0); rq.push_back({2'b01, 4'h3});
    observe;
    tick;
    req_valid = '0; mem_rvalid = 1'b1; mem_rdata = 4'h3;
    for (int k = 0; k < 2; k++) begin
      observe;
      chk("bp_mem_rready", 16'(mem_rready), 16'd0);
      chk("bp_rsp_valid", 16'(rsp_valid), 16'd1);
      tick;
    end
    rsp_ready = 2'b01;
    observe;
    chk("bp_mem_rready_go", 16'(mem_rready), 16'd1);
    tick;
    mem_rvalid = 1'b0; rsp_ready = '0; setr(1, 1, 1, 4'd8, 4'hC); push_cmd(1, 1, 4'd8, 4'hC);
    observe;
    chk("bp_after_ready", 16'(req_ready), 16'd2);
    tick;
    // command backpressure: grant frozen on req1 once req0 joins
    req_valid = '0; mem_ready = 1'b0; setr(1, 1, 1, 4'hD, 4'h5);
    observe;
    chk("hold_addr1", 16'(mem_addr), 16'hD);
    chk("hold_ready1", 16'(req_ready), 16'd0);
    tick;
    setr(0, 1, 1, 4'hE, 4'h6);
    observe;
    chk("hold_addr2", 16'(mem_addr), 16'hD);
    chk("hold_ready2", 16'(req_ready), 16'd0);
    tick;
    mem_ready = 1'b1; push_cmd(1, 1, 4'hD, 4'h5);
    observe;
    chk("hold_fire_ready", 16'(req_ready), 16'd2);
    tick;
    // reset while a read is outstanding
    req_valid = '0; setr(0, 1, 0, 4'd2, 4'h0); push_cmd(0, 0, 4'd2, 4'h0);
    observe;
    tick;
    req_valid = '0; mem_rvalid = 1'b1; mem_rdata = 4'h5;
    observe;
    chk("rst_rd_rsp_before", 16'(rsp_valid), 16'd1);
    rstn = 1'b0; rsp_ready = 2'b01;
    #1;
    chk("rst_rd_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rd_mem_rready", 16'(mem_rready), 16'd0);
    chk("rst_rd_rsp_data", 16'(rsp_data), 16'd0);
    chk("rst_rd_mem_valid", 16'(mem_valid), 16'd0);
    tick;
    mem_rvalid = 1'b0; rsp_ready = '0; rstn = 1'b1;
    setr(0, 1, 1, 4'd1, 4'h1); setr(1, 1, 1, 4'd2, 4'h2); push_cmd(0, 1, 4'd1, 4'h1);
    observe;
    chk("post_rst_tie", 16'(req_ready), 16'd1);
    tick;
    w = FIX ? 1'b0 : 1'b1;
    push_cmd(w, 1'b1, w ? 4'd2 : 4'd1, w ? 4'h2 : 4'h1);
    observe;
    chk("post_rst_tie2", 16'(req_ready), w ? 16'd2 : 16'd1);
    tick;
    req_valid = '0; mem_ready = 1'b0;
    tick;
    chk("cmd_queue_drained", 16'(cq.size()), 16'd0);
    chk("rsp_queue_drained", 16'(rq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
